// File: rtl/sha256_cu.sv
// Single-block SHA-256 cracking unit: pads a <=32-byte candidate and hashes it continuously.
// state | meaning: LOAD = latch/pad input | ROUND = 64 compression rounds | DONE = publish digest
module sha256_cu (
   input  logic         clk,
   input  logic         reset,
   input  logic [255:0] data,
   input  logic [63:0]  data_length,
   output logic [255:0] Hash_Digest,
   output logic         overflow_err
);

   typedef enum logic [1:0] {S_LOAD, S_ROUND, S_DONE} state_t;

   localparam logic [31:0] IV [0:7] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam logic [31:0] K_ROM [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] big_sig0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] big_sig1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] small_sig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] small_sig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   state_t        r_state;
   logic [5:0]    r_t;
   logic [31:0]   r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;
   logic [31:0]   r_w [0:15];
   logic [255:0]  r_digest;
   logic          r_ovf;

   logic [8:0]    w_bits;
   logic [255:0]  w_mask;
   logic [511:0]  w_block;
   logic          w_len_ovf;
   logic [31:0]   w_wnext;
   logic [31:0]   w_ch;
   logic [31:0]   w_maj;
   logic [31:0]   w_t1;
   logic [31:0]   w_t2;

   assign Hash_Digest  = r_digest;
   assign overflow_err = r_ovf;

   // Block layout: message left-justified, 0x80 right after it, bit length in the low 64 bits.
   always_comb begin
      w_len_ovf = (data_length > 64'd32);
      w_bits    = {data_length[5:0], 3'b000};
      w_mask    = {256{1'b1}} >> (9'd256 - w_bits);
      w_block   = ({data & w_mask, 256'b0} << (9'd256 - w_bits))
                | ({1'b1, 511'b0} >> w_bits)
                | {503'b0, w_bits};
   end

   // Window always holds W[t..t+15]; the next word is appended as the oldest drops out.
   always_comb begin
      w_wnext = small_sig1(r_w[14]) + r_w[9] + small_sig0(r_w[1]) + r_w[0];
      w_ch    = (r_e & r_f) ^ (~r_e & r_g);
      w_maj   = (r_a & r_b) ^ (r_a & r_c) ^ (r_b & r_c);
      w_t1    = r_h + big_sig1(r_e) + w_ch + K_ROM[r_t] + r_w[0];
      w_t2    = big_sig0(r_a) + w_maj;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_LOAD;
         r_t      <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_c      <= '0;
         r_d      <= '0;
         r_e      <= '0;
         r_f      <= '0;
         r_g      <= '0;
         r_h      <= '0;
         r_digest <= '0;
         r_ovf    <= 1'b0;
         for (int i = 0; i < 16; i++) r_w[i] <= '0;
      end else begin
         case (r_state)
            S_LOAD: begin
               if (w_len_ovf) begin
                  r_ovf    <= 1'b1;
                  r_digest <= '0;
               end else begin
                  r_ovf <= 1'b0;
                  for (int i = 0; i < 16; i++) r_w[i] <= w_block[511 - 32*i -: 32];
                  r_a     <= IV[0];
                  r_b     <= IV[1];
                  r_c     <= IV[2];
                  r_d     <= IV[3];
                  r_e     <= IV[4];
                  r_f     <= IV[5];
                  r_g     <= IV[6];
                  r_h     <= IV[7];
                  r_t     <= '0;
                  r_state <= S_ROUND;
               end
            end
            S_ROUND: begin
               r_h <= r_g;
               r_g <= r_f;
               r_f <= r_e;
               r_e <= r_d + w_t1;
               r_d <= r_c;
               r_c <= r_b;
               r_b <= r_a;
               r_a <= w_t1 + w_t2;
               for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
               r_w[15] <= w_wnext;
               r_t     <= r_t + 6'd1;
               if (r_t == 6'd63) r_state <= S_DONE;
            end
            S_DONE: begin
               r_digest <= {IV[0] + r_a, IV[1] + r_b, IV[2] + r_c, IV[3] + r_d,
                            IV[4] + r_e, IV[5] + r_f, IV[6] + r_g, IV[7] + r_h};
               r_state  <= S_LOAD;
            end
            default: r_state <= S_LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_cu.sv
// Directed bench for sha256_cu: expected digests queued on stimulus, popped and asserted at output time.
module tb_sha256_cu;

   logic         clk;
   logic         reset;
   logic [255:0] data;
   logic [63:0]  data_length;
   logic [255:0] Hash_Digest;
   logic         overflow_err;

   int n_assert = 0;
   int n_fail   = 0;

   localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

   localparam logic [31:0] TK [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };
   localparam logic [31:0] TIV [0:7] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   typedef struct {
      string        tag;
      logic [255:0] dig;
      logic         ovf;
   } exp_t;

   exp_t sb_q[$];

   sha256_cu dut (
      .clk          (clk),
      .reset        (reset),
      .data         (data),
      .data_length  (data_length),
      .Hash_Digest  (Hash_Digest),
      .overflow_err (overflow_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Reference SHA-256 over the bytes of a right-aligned message of len <= 32 bytes.
   function automatic logic [255:0] sha_model(input logic [255:0] msg, input int len);
      logic [7:0]  blk [0:63];
      logic [31:0] w [0:63];
      logic [31:0] h [0:7];
      logic [31:0] s0, s1, t1, t2, ch, mj;
      logic [63:0] bl;
      for (int i = 0; i < 64; i++) blk[i] = 8'h00;
      for (int i = 0; i < len; i++) blk[i] = msg[8*len - 1 - 8*i -: 8];
      blk[len] = 8'h80;
      bl = 64'(len) * 64'd8;
      for (int j = 0; j < 8; j++) blk[56 + j] = bl[63 - 8*j -: 8];
      for (int t = 0; t < 16; t++) w[t] = {blk[4*t], blk[4*t+1], blk[4*t+2], blk[4*t+3]};
      for (int t = 16; t < 64; t++) begin
         s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
         s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
         w[t] = w[t-16] + s0 + w[t-7] + s1;
      end
      for (int i = 0; i < 8; i++) h[i] = TIV[i];
      for (int t = 0; t < 64; t++) begin
         s1 = rr(h[4], 6) ^ rr(h[4], 11) ^ rr(h[4], 25);
         ch = (h[4] & h[5]) ^ (~h[4] & h[6]);
         t1 = h[7] + s1 + ch + TK[t] + w[t];
         s0 = rr(h[0], 2) ^ rr(h[0], 13) ^ rr(h[0], 22);
         mj = (h[0] & h[1]) ^ (h[0] & h[2]) ^ (h[1] & h[2]);
         t2 = s0 + mj;
         for (int i = 7; i > 0; i--) h[i] = h[i-1];
         h[4] = h[4] + t1;
         h[0] = t1 + t2;
      end
      return {TIV[0] + h[0], TIV[1] + h[1], TIV[2] + h[2], TIV[3] + h[3],
              TIV[4] + h[4], TIV[5] + h[5], TIV[6] + h[6], TIV[7] + h[7]};
   endfunction

   task automatic push(input string tag, input logic [255:0] d, input logic o);
      exp_t e;
      e.tag = tag;
      e.dig = d;
      e.ovf = o;
      sb_q.push_back(e);
   endtask

   task automatic check_pop();
      exp_t e;
      n_assert++;
      assert (sb_q.size() > 0) else begin
         n_fail++;
         $error("FAIL scoreboard_empty: observed 0 queued entries, expected at least 1");
      end
      if (sb_q.size() == 0) return;
      e = sb_q.pop_front();
      n_assert++;
      assert (Hash_Digest === e.dig) else begin
         n_fail++;
         $error("FAIL %s digest: observed %h expected %h", e.tag, Hash_Digest, e.dig);
      end
      n_assert++;
      assert (overflow_err === e.ovf) else begin
         n_fail++;
         $error("FAIL %s overflow_err: observed %b expected %b", e.tag, overflow_err, e.ovf);
      end
   endtask

   task automatic wait_edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   logic [255:0] rnd;
   logic [255:0] exp_abd;

   initial begin
      reset       = 1'b1;
      data        = 256'h616263;
      data_length = 64'd3;

      // reset state
      push("reset", '0, 1'b0);
      wait_edges(3);
      check_pop();

      // first hash: nothing before edge 66, abc at edge 66, then held and repeated
      @(negedge clk);
      reset = 1'b0;
      push("latency_65", '0, 1'b0);
      wait_edges(65);
      check_pop();
      push("abc_first", DIG_ABC, 1'b0);
      wait_edges(1);
      check_pop();
      push("abc_hold", DIG_ABC, 1'b0);
      wait_edges(65);
      check_pop();
      push("abc_repeat", DIG_ABC, 1'b0);
      wait_edges(1);
      check_pop();

      // empty message
      data_length = 64'd0;
      push("empty", DIG_EMPTY, 1'b0);
      wait_edges(66);
      check_pop();

      // 32 random bytes, maximum legal length
      rnd = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
      data        = rnd;
      data_length = 64'd32;
      push("len32", sha_model(rnd, 32), 1'b0);
      wait_edges(66);
      check_pop();

      // overflow lengths: stuck in LOAD with zero digest
      data_length = 64'd33;
      push("ovf33", '0, 1'b1);
      wait_edges(1);
      check_pop();
      push("ovf33_stay", '0, 1'b1);
      wait_edges(4);
      check_pop();
      data_length = 64'd64;
      push("ovf64", '0, 1'b1);
      wait_edges(1);
      check_pop();
      data_length = 64'd1 << 40;
      push("ovf2p40", '0, 1'b1);
      wait_edges(1);
      check_pop();

      // recover with abc, junk above the message bytes must be ignored
      data        = {rnd[255:24], 24'h616263};
      data_length = 64'd3;
      push("ovf_clear", '0, 1'b0);
      wait_edges(1);
      check_pop();
      push("abc_recover", DIG_ABC, 1'b0);
      wait_edges(65);
      check_pop();

      // change data mid-hash: current period unaffected, next one picks it up
      exp_abd = sha_model(256'h616264, 3);
      push("abc_midchange", DIG_ABC, 1'b0);
      wait_edges(20);
      data[23:0] = 24'h616264;
      wait_edges(46);
      check_pop();
      push("abd", exp_abd, 1'b0);
      wait_edges(66);
      check_pop();

      // asynchronous reset at round 30, then a full restart
      wait_edges(31);
      #2;
      reset = 1'b1;
      push("reset_mid", '0, 1'b0);
      #1;
      check_pop();
      @(negedge clk);
      reset = 1'b0;
      push("restart_65", '0, 1'b0);
      wait_edges(65);
      check_pop();
      push("restart_abd", exp_abd, 1'b0);
      wait_edges(1);
      check_pop();

      // reset clears a pending overflow flag asynchronously
      data_length = 64'd40;
      push("ovf40", '0, 1'b1);
      wait_edges(2);
      check_pop();
      #2;
      reset = 1'b1;
      push("reset_ovf", '0, 1'b0);
      #1;
      check_pop();
      @(negedge clk);
      reset = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
